// File: rtl/counter_pkg.sv
// counter_pkg: shared constants and types for the enable-gated wrap counter.
//   DEF_WIDTH   - default counter width in bits
//   DEF_MAX_VAL - default terminal count (all ones at the default width)
//   count_t     - count word at the default width
package counter_pkg;

    localparam int unsigned DEF_WIDTH   = 4;
    localparam int unsigned DEF_MAX_VAL = 15;

    typedef logic [DEF_WIDTH-1:0] count_t;

endpackage

// File: rtl/modport_counter.sv
// modport_counter: free-running, enable-gated up-counter with a registered
// one-cycle wrap pulse. Counts 0..MAX_VAL, then wraps to 0.
//
// Parameters:
//   WIDTH    - counter width in bits
//   MAX_VAL  - terminal count, legal range 1..2**WIDTH-1
// Ports:
//   clk      - in,  rising-edge clock
//   rst      - in,  synchronous active-high reset, dominates all inputs
//   enable   - in,  count enable, sampled at the rising edge
//   count    - out, current count (registered)
//   overflow - out, high for the one cycle in which count reads 0 after a wrap
module modport_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned MAX_VAL = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             overflow
);

    // Parameter legality, caught at elaboration.
    if (WIDTH < 1 || WIDTH > 31) begin : gen_bad_width
        $fatal(1, "modport_counter: WIDTH must be 1..31");
    end
    if (MAX_VAL < 1 || MAX_VAL > 2**WIDTH - 1) begin : gen_bad_max
        $fatal(1, "modport_counter: MAX_VAL must be 1..2**WIDTH-1");
    end

    localparam logic [WIDTH-1:0] MAX_CNT = MAX_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] count_next;
    logic             overflow_next;

    // Next-state. The >= also catches a corrupted count above MAX_VAL, which
    // is recovered by wrapping to 0 with an overflow pulse. Below MAX_VAL the
    // increment can never exceed WIDTH bits.
    always_comb begin
        count_next    = count;
        overflow_next = 1'b0;
        if (enable) begin
            if (count >= MAX_CNT) begin
                count_next    = '0;
                overflow_next = 1'b1;
            end else begin
                count_next    = count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            count    <= count_next;
            overflow <= overflow_next;
        end
    end

`ifndef SYNTHESIS
    // A wrap pulse always coincides with a zero count.
    a_ovf_zero : assert property (@(posedge clk) disable iff (rst)
        overflow |-> (count == '0));

    // Wraps can only be back-to-back when the count range is 0..1.
    if (MAX_VAL > 1) begin : gen_no_double
        a_ovf_single : assert property (@(posedge clk) disable iff (rst)
            overflow |=> !overflow);
    end

    a_rst_clear : assert property (@(posedge clk)
        rst |=> (count == '0 && !overflow));
`endif

endmodule

// File: tb/tb_modport_counter.sv
// tb_modport_counter: scoreboard bench for modport_counter at default
// parameters. Each driven cycle pushes the expected (count, overflow) pair;
// the pair is popped and compared #1 after the following rising edge.
module tb_modport_counter;
    import counter_pkg::*;

    localparam int unsigned MAX = DEF_MAX_VAL;

    typedef struct {
        int unsigned cnt;
        logic        ovf;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   enable = 1'b1;
    count_t count;
    logic   overflow;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    exp_t        sb_q[$];
    int unsigned m_cnt = 0;
    logic        m_ovf = 1'b0;
    int unsigned n_en  = 0;
    int unsigned n_ovf = 0;

    modport_counter dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle, predict its outcome, then compare after the edge.
    task automatic step(input logic r, input logic e, input string tag);
        exp_t ex;
        exp_t got_ex;
        rst    = r;
        enable = e;
        if (r) begin
            m_cnt = 0;
            m_ovf = 1'b0;
        end else if (e) begin
            if (m_cnt == MAX) begin
                m_cnt = 0;
                m_ovf = 1'b1;
            end else begin
                m_cnt = m_cnt + 1;
                m_ovf = 1'b0;
            end
        end else begin
            m_ovf = 1'b0;
        end
        ex.cnt = m_cnt;
        ex.ovf = m_ovf;
        sb_q.push_back(ex);
        @(posedge clk);
        #1;
        got_ex = sb_q.pop_front();
        check({tag, "_count"}, 32'(count), 32'(got_ex.cnt));
        check({tag, "_ovf"}, 32'(overflow), 32'(got_ex.ovf));
    endtask

    initial begin
        // Reset with enable high.
        step(1'b1, 1'b1, "reset0");
        step(1'b1, 1'b1, "reset1");

        // 1..15 without overflow.
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, "count");
        check("at_max", 32'(count), 32'd15);

        // Wrap, then resume.
        step(1'b0, 1'b1, "wrap");
        check("wrap_ovf", 32'(overflow), 32'd1);
        step(1'b0, 1'b1, "after_wrap");
        check("after_wrap_cnt", 32'(count), 32'd1);

        // Up to 7, hold for 5 cycles, re-enable.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, "to7");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, "hold");
        check("hold_cnt", 32'(count), 32'd7);
        step(1'b0, 1'b1, "reenable");
        check("reenable_cnt", 32'(count), 32'd8);

        // Reset at 15 with enable high beats the wrap.
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, "to15");
        check("pre_rst_cnt", 32'(count), 32'd15);
        step(1'b1, 1'b1, "rst_at_max");
        check("rst_at_max_ovf", 32'(overflow), 32'd0);

        // Random enable from 0; one overflow per 16 enabled cycles.
        for (int i = 0; i < 200; i++) begin
            logic e;
            e = 1'($urandom_range(0, 1));
            if (e) n_en++;
            step(1'b0, e, "rand");
            if (overflow) n_ovf++;
        end
        check("rand_ovf_total", 32'(n_ovf), 32'(n_en / 16));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/modport_counter.md
# modport_counter

Free-running, enable-gated up-counter with a registered wrap (overflow) indication. It is the leaf datapath block behind the counter verification interface. A driver controls reset and enable; a monitor samples count and overflow on every rising clock edge. Width and terminal value are parameterised; the defaults give a 4-bit counter wrapping 15→0.

## Interface
One clock `clk`; reset `rst` is synchronous and active-high.

Parameters:
- `WIDTH`, default 4: counter width in bits.
- `MAX_VAL`, default 2**WIDTH-1: terminal count. After this value the counter wraps to 0. Legal range 1..2**WIDTH-1.

Ports:
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: synchronous active-high reset.
- `enable`, input, 1: count-enable, sampled at the rising edge of `clk`.
- `count`, output, WIDTH: current count, registered.
- `overflow`, output, 1: one-cycle pulse, registered, marking a wrap.

## Operation
- Reset has priority over all other inputs. On any edge with `rst`=1: `count`←0 and `overflow`←0.
- With `rst`=0 and `enable`=1:
  - If `count`<MAX_VAL: `count`←`count`+1 and `overflow`←0.
  - If `count`==MAX_VAL: `count`←0 and `overflow`←1.
- With `rst`=0 and `enable`=0: `count` holds and `overflow`←0. An overflow pulse never stretches.
- Arithmetic is unsigned, modulo MAX_VAL+1. No intermediate value exceeds WIDTH bits.
- Out-of-range state (`count`>MAX_VAL, reachable only when MAX_VAL<2**WIDTH-1 and state is corrupted): the next enabled edge loads 0 and asserts `overflow`.
- No combinational path from any input to any output.

## Timing
- Latency is 1 cycle from a sampled `enable` to the updated `count` and `overflow`.
- `overflow` is high in exactly the cycle in which `count` first reads 0 after a wrap.
- Back-to-back wraps are possible only when MAX_VAL=1 with `enable` held high. In that case `overflow` pulses every second cycle.
- Reset mid-count: on the next edge `count`=0 and `overflow`=0, regardless of `enable`. Counting resumes on the first edge with `rst`=0 and `enable`=1.
- Reset asserted on the same edge as a wrap: reset wins and `overflow` stays 0.
- Outputs are stable from clock-to-q until the next edge. The bench samples them with a small input skew after the edge.

## Structure
- Shared package `counter_pkg` holds:
  - default `WIDTH` (4) and `MAX_VAL` (15) constants;
  - typedef `count_t` = logic [WIDTH-1:0].
- Single module, no sub-modules. A separate wrap-detect comparator is not warranted; it stays inline as `count`==MAX_VAL.
- Include parameter-legality checks, e.g. elaboration-time assertion that MAX_VAL≥1 and MAX_VAL<2**WIDTH.
- Include SVA properties inside the module, disabled for synthesis:
  - `overflow` implies `count`==0;
  - `overflow` never high two consecutive cycles when MAX_VAL>1;
  - `rst` implies next `count`==0.

## Test plan
- Reset: assert `rst` for 2 cycles with `enable`=1 → `count`=0 and `overflow`=0 on every sampled edge.
- Count sequence: release `rst` and hold `enable`=1 for 15 cycles → `count` reads 1,2,…,15 with `overflow`=0 throughout.
- Wrap: one more enabled cycle from 15 → `count`=0 and `overflow`=1 for exactly one cycle; next cycle `count`=1 and `overflow`=0.
- Hold: at `count`=7 drive `enable`=0 for 5 cycles → `count` stays 7 and `overflow`=0; re-enable → 8.
- Reset mid-operation: at `count`=15 assert `rst` with `enable`=1 → next `count`=0 and `overflow`=0. No overflow pulse.
- Random `enable` for 200 cycles vs. a reference model → `count` matches; `overflow` pulses exactly once per 16 enabled cycles.
